encoder_layer_1_intermediate_dense_bias_add: RTL and testbench
==============================================================

// Module: encoder_layer_1_intermediate_dense_bias_add
// PURPOSE
//  Downstream consumer of encoder_layer_1_intermediate_dense_bias_source.
//  - Joins the intermediate-dense matmul output stream with the bias stream.
//  - Adds them element-wise in fixed point, requantises and saturates to the output format.
//  - Drives the next stage (activation) through a 2-entry skid buffer.
//  - Tracks beat position so each bias element pairs with the matching data column block.
// PARAMETERS
//  DATA_IN_PRECISION_0      16  data_in total width (signed)
//  DATA_IN_PRECISION_1       3  data_in fraction bits
//  BIAS_PRECISION_0         16  bias total width (signed)
//  BIAS_PRECISION_1          3  bias fraction bits
//  DATA_OUT_PRECISION_0     16  data_out total width (signed)
//  DATA_OUT_PRECISION_1      3  data_out fraction bits
//  TENSOR_SIZE_DIM_0        32  elements per row
//  PARALLELISM_DIM_0         1  elements per beat, lanes (P); must divide TENSOR_SIZE_DIM_0
//  DEPTH    TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0  beats per row
// PORTS
//  clk             in   1                       clock, rising edge
//  rst             in   1                       asynchronous, active-low reset
//  data_in         in   P x DATA_IN_PRECISION_0 matmul result lanes
//  data_in_valid   in   1
//  data_in_ready   out  1
//  bias            in   P x BIAS_PRECISION_0    bias lanes from the bias source
//  bias_valid      in   1
//  bias_ready      out  1
//  data_out        out  P x DATA_OUT_PRECISION_0
//  data_out_valid  out  1
//  data_out_ready  in   1
//  data_out_last   out  1                       high on the final beat of a row (beat DEPTH-1)
//  overflow        out  1                       sticky: set when any lane saturated since reset
// BEHAVIOUR
//  - Reset (rst=0, async): skid buffer empty, beat counter 0, overflow 0.
//    Outputs: data_out_valid 0, data_out_last 0, data_out 0.
//  - Join:
//    - space = (occupancy < 2), taken from registered occupancy only.
//    - data_in_ready = bias_valid & space; bias_ready = data_in_valid & space.
//    - Accept occurs when data_in_valid & bias_valid & space. Both streams transfer in the same cycle, never one alone.
//  - Ready paths carry no combinational path from data_out_ready. When occupancy==2, ready stays 0 for that cycle even if the head drains.
//  - Arithmetic, per lane:
//    - Align bias to DATA_IN_PRECISION_1: shift left if its fraction is smaller; arithmetic right-shift (floor) if larger.
//    - Sum width = max(aligned widths)+1; this width never overflows.
//    - Requantise to DATA_OUT_PRECISION_1 with floor. Saturate to [-2^(W-1), 2^(W-1)-1], W = DATA_OUT_PRECISION_0.
//    - Any saturating lane on an accepted beat sets overflow in the cycle after accept.
//  - Latency: the beat is written into the buffer at the accepting edge; data_out_valid is high the next cycle.
//  - Throughput is 1 beat/cycle while data_out_ready=1.
//  - Buffer is FIFO ordered, 2 entries. A simultaneous push and pop keeps occupancy unchanged.
//  - data_out and data_out_last hold stable while data_out_valid=1 and data_out_ready=0.
//  - Beat counter:
//    - Increments on each accept and wraps DEPTH-1 -> 0.
//    - data_out_last is stored per entry and is 1 when the counter was DEPTH-1 at accept.
//    - With DEPTH==1, every beat is last.
//  - Reset mid-operation flushes the buffer and discards in-flight beats. The counter returns to 0 and no partial beat is emitted.
// TESTING
//  1. Defaults, P=1: data_in=0x0010 (2.0), bias=0x0008 (1.0), both valid, ready=1.
//     -> next cycle data_out=0x0018, data_out_valid=1, overflow=0.
//  2. data_in=0x7FF0, bias=0x0100 -> data_out=0x7FFF, overflow=1 and stays 1.
//     Then data_in=0x8010, bias=0xFF00 -> data_out=0x8000.
//  3. 32 consecutive beats, valid=1, ready=1:
//     -> data_out_last high only on beats 31, 63, ...; throughput 1/cycle, no bubbles.
//  4. data_out_ready=0 for 5 cycles while streaming 4 beats:
//     -> exactly 2 accepted, then data_in_ready=bias_ready=0.
//     After release, all 4 emerge in order, none lost or duplicated.
//  5. bias_valid=0 with data_in_valid=1 -> data_in_ready=0, no accept, counter unchanged.
//     The converse case (data_in_valid=0 with bias_valid=1) behaves symmetrically.
//  6. Assert rst low mid-row with 2 beats buffered:
//     -> data_out_valid=0 immediately and overflow=0.
//     After release, the first accepted beat is treated as beat 0.

Source files
------------

// File: rtl/encoder_layer_1_intermediate_dense_bias_add.sv
// Joins the intermediate-dense matmul stream with its bias stream, adds per lane,
// requantises with floor, saturates, and presents results through a 2-entry buffer.
module encoder_layer_1_intermediate_dense_bias_add #(
  parameter int DATA_IN_PRECISION_0  = 16,
  parameter int DATA_IN_PRECISION_1  = 3,
  parameter int BIAS_PRECISION_0     = 16,
  parameter int BIAS_PRECISION_1     = 3,
  parameter int DATA_OUT_PRECISION_0 = 16,
  parameter int DATA_OUT_PRECISION_1 = 3,
  parameter int TENSOR_SIZE_DIM_0    = 32,
  parameter int PARALLELISM_DIM_0    = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [PARALLELISM_DIM_0*DATA_IN_PRECISION_0-1:0]  data_in,
  input  logic                                             data_in_valid,
  output logic                                             data_in_ready,
  input  logic [PARALLELISM_DIM_0*BIAS_PRECISION_0-1:0]     bias,
  input  logic                                             bias_valid,
  output logic                                             bias_ready,
  output logic [PARALLELISM_DIM_0*DATA_OUT_PRECISION_0-1:0] data_out,
  output logic                                             data_out_valid,
  input  logic                                             data_out_ready,
  output logic                                             data_out_last,
  output logic                                             overflow
);

  localparam int P      = PARALLELISM_DIM_0;
  localparam int DIN_W  = DATA_IN_PRECISION_0;
  localparam int DIN_F  = DATA_IN_PRECISION_1;
  localparam int B_W    = BIAS_PRECISION_0;
  localparam int B_F    = BIAS_PRECISION_1;
  localparam int DOUT_W = DATA_OUT_PRECISION_0;
  localparam int DOUT_F = DATA_OUT_PRECISION_1;
  localparam int DEPTH  = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam int B_LSH  = (B_F < DIN_F) ? (DIN_F - B_F) : 0;
  localparam int B_RSH  = (B_F > DIN_F) ? (B_F - DIN_F) : 0;
  localparam int BA_W   = B_W + B_LSH;
  localparam int S_W    = ((DIN_W > BA_W) ? DIN_W : BA_W) + 1;
  localparam int Q_LSH  = (DOUT_F > DIN_F) ? (DOUT_F - DIN_F) : 0;
  localparam int Q_RSH  = (DOUT_F < DIN_F) ? (DIN_F - DOUT_F) : 0;
  localparam int Q_W    = S_W + Q_LSH;
  localparam int DW     = P * DOUT_W;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Input side is a join: both streams move together or neither does. Readies come
  // only from registered occupancy, never from data_out_ready.
  logic [1:0]  count;
  logic        space;
  logic        accept;
  logic        pop;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic        beat_last;

  logic [DW-1:0] mem_data [2];
  logic          mem_last [2];

  logic [DW-1:0] lane_result;
  logic [P-1:0]  lane_sat;

  assign space         = (count != 2'd2);
  assign data_in_ready = bias_valid & space;
  assign bias_ready    = data_in_valid & space;
  assign accept        = data_in_valid & bias_valid & space;
  assign pop           = data_out_valid & data_out_ready;
  assign beat_last     = (beat_cnt == CNT_W'(DEPTH - 1));

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic signed [DIN_W-1:0] d_lane;
    logic signed [B_W-1:0]   b_lane;
    logic signed [BA_W-1:0]  b_al;
    logic signed [S_W-1:0]   sum;
    logic signed [Q_W-1:0]   q;

    assign d_lane = $signed(data_in[l*DIN_W +: DIN_W]);
    assign b_lane = $signed(bias[l*B_W +: B_W]);
    // Only one of each shift pair is non-zero; >>> floors negative values.
    assign b_al   = $signed(BA_W'(b_lane) <<< B_LSH) >>> B_RSH;
    assign sum    = S_W'(d_lane) + S_W'(b_al);
    assign q      = $signed(Q_W'(sum) <<< Q_LSH) >>> Q_RSH;

    if (Q_W > DOUT_W) begin : g_sat
      logic [Q_W-DOUT_W:0] hi;
      assign hi = q[Q_W-1:DOUT_W-1];
      // Fits when all bits above the output sign bit match it.
      assign lane_sat[l] = !((&hi) || !(|hi));
      assign lane_result[l*DOUT_W +: DOUT_W] =
        !lane_sat[l]   ? q[DOUT_W-1:0] :
        q[Q_W-1]       ? {1'b1, {(DOUT_W-1){1'b0}}} :
                         {1'b0, {(DOUT_W-1){1'b1}}};
    end else begin : g_nosat
      assign lane_sat[l] = 1'b0;
      assign lane_result[l*DOUT_W +: DOUT_W] = DOUT_W'(q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      beat_cnt <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        mem_data[wr_ptr] <= lane_result;
        mem_last[wr_ptr] <= beat_last;
        wr_ptr           <= ~wr_ptr;
        beat_cnt         <= beat_last ? '0 : beat_cnt + 1'b1;
        overflow         <= overflow | (|lane_sat);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign data_out_valid = (count != 2'd0);
  assign data_out       = data_out_valid ? mem_data[rd_ptr] : '0;
  assign data_out_last  = data_out_valid & mem_last[rd_ptr];

endmodule

// File: tb/tb_encoder_layer_1_intermediate_dense_bias_add.sv
// Directed bench for the bias-add join: expectations queued at accept time,
// checked by an independent output monitor.
module tb_encoder_layer_1_intermediate_dense_bias_add;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [15:0] bias;
  logic        bias_valid;
  logic        bias_ready;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        data_out_last;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;
  int beat_idx    = 0;
  int cyc         = 0;
  logic [16:0] exp_q[$];

  encoder_layer_1_intermediate_dense_bias_add dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .bias           (bias),
    .bias_valid     (bias_valid),
    .bias_ready     (bias_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last),
    .overflow       (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] e);
    exp_q.push_back({(beat_idx == 31), e});
    beat_idx = (beat_idx + 1) % 32;
  endtask

  // driver: present one beat on both streams until accepted
  task automatic send(input logic [15:0] d, input logic [15:0] b, input logic [15:0] e);
    bit done = 0;
    data_in = d; bias = b; data_in_valid = 1'b1; bias_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (data_in_ready && bias_ready) done = 1;
    end
    if (!done) check("send_timeout", 0, 1);
    else push_exp(e);
    @(posedge clk); #1;
    data_in_valid = 1'b0; bias_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst && data_out_valid && data_out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", data_out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", data_out, e[15:0]);
        check("data_out_last", data_out_last, e[16]);
      end
    end
  end

  initial begin
    int k;
    int c0;
    bit acc;
    data_in = '0; bias = '0; data_in_valid = 0; bias_valid = 0; data_out_ready = 1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", data_out_valid, 0);
    check("rst_last", data_out_last, 0);
    check("rst_data", data_out, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // basic add: 2.0 + 1.0 = 3.0
    send(16'h0010, 16'h0008, 16'h0018);
    check("ovf_after_basic", overflow, 0);
    // -1.0 + -0.5 = -1.5
    send(16'hFFF8, 16'hFFFC, 16'hFFF4);
    check("ovf_after_neg", overflow, 0);

    // saturation both ways; overflow is sticky
    send(16'h7FF0, 16'h0100, 16'h7FFF);
    check("ovf_set", overflow, 1);
    send(16'h8010, 16'hFF00, 16'h8000);
    send(16'h0020, 16'h0008, 16'h0028);
    check("ovf_sticky", overflow, 1);
    drain();

    // back-to-back row stream, last on beat 31 of the row
    c0 = cyc;
    for (int i = 0; i < 40; i++)
      send(16'(i * 8), 16'h0008, 16'(i * 8 + 8));
    check("throughput_cycles", cyc - c0, 40);
    drain();

    // output stall: only two beats fit
    data_out_ready = 0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      data_in = 16'h0100 + 16'(k * 8); bias = 16'h0000;
      data_in_valid = 1; bias_valid = 1;
      @(negedge clk);
      acc = data_in_ready && bias_ready;
      if (acc) push_exp(16'h0100 + 16'(k * 8));
      @(posedge clk); #1;
      if (acc) k++;
    end
    check("stall_accepts", k, 2);
    check("stall_din_ready", data_in_ready, 0);
    check("stall_bias_ready", bias_ready, 0);
    check("stall_hold_data", data_out, 16'h0100);
    data_in_valid = 0; bias_valid = 0;
    data_out_ready = 1;
    send(16'h0110, 16'h0000, 16'h0110);
    send(16'h0118, 16'h0000, 16'h0118);
    drain();

    // one-sided valid never transfers
    data_in = 16'h0040; bias = 16'h0008; data_in_valid = 1; bias_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("join_din_ready", data_in_ready, 0);
    check("join_bias_ready", bias_ready, 1);
    data_in_valid = 0; bias_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    check("join_bias_ready2", bias_ready, 0);
    check("join_din_ready2", data_in_ready, 1);
    check("join_no_output", data_out_valid, 0);
    bias_valid = 0;
    // counter must be unchanged: continue the row and let last flags confirm it
    for (int i = 0; i < 30; i++)
      send(16'(i), 16'h0000, 16'(i));
    drain();

    // reset mid-row with two beats buffered
    data_out_ready = 0;
    send(16'h0008, 16'h0008, 16'h0010);
    send(16'h0010, 16'h0008, 16'h0018);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", data_out_valid, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_ready", data_in_ready, 0);
    exp_q.delete();
    beat_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    data_out_ready = 1;
    for (int i = 0; i < 32; i++)
      send(16'(i * 16), 16'hFFF8, 16'(i * 16 - 8));
    drain();
    check("final_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
